// File: rtl/map_port_arbiter.sv
// map_port_arbiter: round-robin sharing of the map ROM collision-read port.
// Requesters present row/column addresses; one is granted per clock, the
// address is registered toward the ROM, and a tag pipeline matched to the
// ROM read latency routes the returned pixel byte back to its requester.
//
// Request/grant handshake: a requester raises req[i] with a stable address
// and keeps both unchanged until it sees gnt[i]=1 in some cycle; that cycle's
// rising edge accepts the request. Before that edge it either drops req[i] or
// presents its next address. Dropping req[i] before a grant is harmless.
// There is no backpressure on responses: rsp_valid is a one-cycle pulse.
module map_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_col,
  input  logic [NUM_REQ*ADDR_W-1:0] req_row,
  input  logic                      hold,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         map_col_addr,
  output logic [ADDR_W-1:0]         map_row_addr,
  input  logic [7:0]                map_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [7:0]                rsp_data,
  output logic                      busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Arbitration pointer and registered ROM address.
  logic [IDW-1:0]    last_q, last_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;

  // Tag pipeline: one valid bit and requester ID per ROM latency stage.
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [IDW-1:0]          pipe_id_q [READ_LATENCY];

  // Response registers.
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;

  // Arbitration results.
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           grant_en;

  // Round-robin search starting just above the last winner, wrapping.
  always_comb begin
    logic [IDW-1:0] idx_w;
    win_found = 1'b0;
    win_id    = '0;
    idx_w     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_w = IDW'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req[idx_w]) begin
        win_found = 1'b1;
        win_id    = idx_w;
      end
    end
    // No grant while held off or while reset is asserted.
    grant_en = win_found && !hold && reset;
    gnt      = grant_en ? (NUM_REQ'(1) << win_id) : '0;
  end

  // Next-state for pointer, ROM address and response registers.
  always_comb begin
    last_d      = last_q;
    col_d       = col_q;
    row_d       = row_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (grant_en) begin
      last_d = win_id;
      col_d  = req_col[win_id*ADDR_W +: ADDR_W];
      row_d  = req_row[win_id*ADDR_W +: ADDR_W];
    end
    // The final tag stage lines up with valid ROM data on this edge.
    if (pipe_vld_q[READ_LATENCY-1]) begin
      rsp_valid_d = NUM_REQ'(1) << pipe_id_q[READ_LATENCY-1];
      rsp_data_d  = map_data;
    end
  end

  // State registers; reset discards all in-flight tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q      <= IDW'(NUM_REQ - 1);
      col_q       <= '0;
      row_q       <= '0;
      pipe_vld_q  <= '0;
      for (int s = 0; s < READ_LATENCY; s++) pipe_id_q[s] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      last_q        <= last_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pipe_vld_q[0] <= grant_en;
      pipe_id_q[0]  <= win_id;
      for (int s = 1; s < READ_LATENCY; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_id_q[s]  <= pipe_id_q[s-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign map_col_addr = col_q;
  assign map_row_addr = row_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = (|pipe_vld_q) || (|rsp_valid_q);

endmodule

// File: doc/map_port_arbiter.md
# map_port_arbiter

Round-robin arbiter sharing the single collision-read port (port A) of the `map` world ROM between up to `NUM_REQ` requesters, e.g. several ball collision checkers and a goal/hole scanner. Each requester presents a row/column address. The arbiter grants one requester per clock and drives the map address registers. It tracks each in-flight read through a tag pipeline matched to the ROM read latency, and returns the pixel byte to the originating requester with a one-cycle valid pulse. The video port (port B) is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters; legal 2..8. ID width `IDW = clog2(NUM_REQ)`.
- `READ_LATENCY`, 2: clocks from `map_col_addr`/`map_row_addr` update edge to the edge at which `map_data` is valid; legal 1..4.
- `ADDR_W`, 10: row/column address width.
- `clk`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clk` upstream.
- `req`  in  NUM_REQ  per-requester read request; held with address stable until granted.
- `req_col`  in  NUM_REQ*ADDR_W  column addresses, requester i at bits [i*ADDR_W +: ADDR_W].
- `req_row`  in  NUM_REQ*ADDR_W  row addresses, same packing.
- `hold`  in  1  when high, no new grants; in-flight reads still complete.
- `gnt`  out  NUM_REQ  one-hot combinational grant, valid in the cycle the request is accepted.
- `map_col_addr`  out  ADDR_W  registered column address to map port A.
- `map_row_addr`  out  ADDR_W  registered row address to map port A.
- `map_data`  in  8  map port A pixel byte.
- `rsp_valid`  out  NUM_REQ  registered one-hot, one-cycle pulse per completed read.
- `rsp_data`  out  8  registered pixel byte, valid only when `rsp_valid` is nonzero.
- `busy`  out  1  high while any read is in the tag pipeline.

## Operation
- Arbitration is combinational each cycle. With `hold`=0 and `req`≠0, the winner is the first set `req` bit scanning upward from `last+1`, wrapping modulo `NUM_REQ`. `gnt` is the one-hot winner; otherwise `gnt`=0.
- On the rising edge ending a grant cycle:
  - `map_col_addr`/`map_row_addr` load the winner's addresses.
  - `last` loads the winner ID.
  - Stage 0 of the tag pipeline loads {valid=1, id=winner}.
- Cycles without a grant load stage 0 with valid=0. Map addresses hold their last value.
- The tag pipeline has `READ_LATENCY` stages and shifts every clock; it never stalls.
- When the last stage is valid, the same edge registers `rsp_data`←`map_data` and `rsp_valid`←onehot(id). Otherwise `rsp_valid`←0 and `rsp_data` holds.
- A requester sees `gnt[i]`=1 and must either drop `req[i]` or present its next address before the next edge. It may keep `req[i]` high for back-to-back reads, but is re-granted only when the rotation returns to it.
- A requester may drop `req` without having been granted; no side effects.
- `busy` = OR of all stage valid bits plus `rsp_valid`≠0.
- No fairness starvation: any held request is granted within `NUM_REQ` grant cycles.

## Timing
- Reset (`reset`=0), all asynchronous:
  - `map_col_addr`=0, `map_row_addr`=0.
  - `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - All pipeline valids=0.
  - `last`=`NUM_REQ`-1, so requester 0 has first priority.
- Reset mid-operation discards in-flight reads; no `rsp_valid` for them after release.
- `gnt` is forced 0 while `reset`=0.
- Latency: `gnt` in cycle T → `rsp_valid` high in cycle T+`READ_LATENCY`+1 (T+3 at default), for exactly one cycle.
- Throughput: one grant per cycle, `READ_LATENCY`+1 reads in flight maximum, responses in grant order.
- `hold` rising in cycle T: no `gnt` in T. Grants issued before T still respond on schedule. `hold` does not alter `last`.
- Simultaneous grant and response in one cycle is normal; they are independent.
- Out-of-range addresses are passed unmodified; the map defines their contents.

## Test plan
- Reset release, `req`=4'b0001, col=0x20F, row=0xFE, `map_data` model = col[7:0]: `gnt`=0001 in cycle 0, map addr=0x20F/0xFE in cycle 1, `rsp_valid`=0001 with `rsp_data`=0x0F in cycle 3.
- `req`=1111 held 8 cycles: grant sequence 0,1,2,3,0,1,2,3. Each `rsp_valid` follows its grant by 3 cycles. `busy` stays high until 3 cycles after the last grant.
- `req`=1010 after requester 3 last granted: grants alternate 1,3,1,3. Requesters 0 and 2 never receive `gnt` or `rsp_valid`.
- `hold`=1 for 4 cycles while `req`=0110 with one read in flight: the in-flight response arrives on time, no `gnt` during hold. The first grant after release goes to requester 1 if `last`=0.
- Assert `reset`=0 one cycle after two grants: no `rsp_valid` afterward. Outputs read 0 immediately, before any clock edge. The first grant after release goes to requester 0.
- `READ_LATENCY`=1 build with a ROM model of latency 1: `rsp_valid` arrives 2 cycles after `gnt`, and `rsp_data` matches the granted address.
